serial_adder: RTL and testbench

- Parametrised bit-serial adder built around one full-adder cell and a carry flip-flop.
- Adds two WIDTH-bit operands LSB-first, one bit per clock.
- Uses a start/busy/done handshake.
- Sequential successor to the combinational half/full adder cells; used where area matters more than latency.

---
 rtl/serial_adder.sv | 123 ++++++++++++
 tb/tb_serial_adder.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_adder.sv
`default_nettype none
// ============================================================================
// Module   : serial_adder
// Brief    : Bit-serial LSB-first adder, one full-adder cell plus carry flop,
//            start/busy/done handshake. Define SERIAL_ADDER_SUB_EN for a - b.
// Revision : 1.0 - initial release
// ============================================================================
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef SERIAL_ADDER_SUB_EN
    input  logic             sub,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int                 c_CNT_W = $clog2(WIDTH) + 1;
    localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(WIDTH - 1);
    localparam logic [c_CNT_W-1:0] c_ONE   = c_CNT_W'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             r_state;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [WIDTH-1:0]   r_sum;
    logic [c_CNT_W-1:0] r_cnt;
    logic               r_carry;
    logic               r_busy;
    logic               r_done;
    logic               r_cout;

    logic [WIDTH-1:0]   w_b_in;
    logic               w_cin_in;
    logic               w_s;
    logic               w_maj;
    logic [WIDTH-1:0]   w_sum_next;

    // Subtraction is a + ~b + 1: invert B on entry and force the carry in.
`ifdef SERIAL_ADDER_SUB_EN
    assign w_b_in   = sub ? ~b : b;
    assign w_cin_in = sub ? 1'b1 : cin;
`else
    assign w_b_in   = b;
    assign w_cin_in = cin;
`endif

    assign w_s   = r_a[0] ^ r_b[0] ^ r_carry;
    assign w_maj = (r_a[0] & r_b[0]) | (r_a[0] & r_carry) | (r_b[0] & r_carry);

    generate
        if (WIDTH == 1) begin : g_one
            assign w_sum_next = w_s;
        end else begin : g_multi
            assign w_sum_next = {w_s, r_sum[WIDTH-1:1]};
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_sum   <= '0;
            r_cnt   <= '0;
            r_carry <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_cout  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_a     <= a;
                        r_b     <= w_b_in;
                        r_carry <= w_cin_in;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= S_RUN;
                    end
                end
                S_RUN: begin
                    r_carry <= w_maj;
                    r_sum   <= w_sum_next;
                    r_a     <= r_a >> 1;
                    r_b     <= r_b >> 1;
                    r_cnt   <= r_cnt + c_ONE;
                    if (r_cnt == c_LAST) begin
                        r_cout  <= w_maj;
                        r_busy  <= 1'b0;
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_done  <= 1'b1;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign sum  = r_sum;
    assign cout = r_cout;

endmodule
`default_nettype wire

// File: tb/tb_serial_adder.sv
`default_nettype none
// ============================================================================
// Module   : tb_serial_adder
// Brief    : Self-checking bench for serial_adder (WIDTH=8 and WIDTH=1).
// Revision : 1.0 - initial release
// ============================================================================
module tb_serial_adder;

    logic       clk;
    logic       rst_n;
    logic       start8, cin8, busy8, done8, cout8;
    logic [7:0] a8, b8, sum8;
    logic       start1, a1, b1, cin1, busy1, done1, sum1, cout1;
`ifdef SERIAL_ADDER_SUB_EN
    logic       sub8;
    logic       sub1;
`endif
    int         n_checks;
    int         n_pass;

    serial_adder #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8), .cin(cin8),
`ifdef SERIAL_ADDER_SUB_EN
        .sub(sub8),
`endif
        .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
    );

    serial_adder #(.WIDTH(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .a(a1), .b(b1), .cin(cin1),
`ifdef SERIAL_ADDER_SUB_EN
        .sub(sub1),
`endif
        .busy(busy1), .done(done1), .sum(sum1), .cout(cout1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: {cout, sum} of the WIDTH=8 operation as plain 9-bit arithmetic.
    function automatic logic [8:0] ref8(input logic [7:0] x, input logic [7:0] y,
                                        input logic c, input logic s);
        if (s) return {1'b0, x} + {1'b0, ~y} + 9'd1;
        return {1'b0, x} + {1'b0, y} + {8'd0, c};
    endfunction

    // Issue one WIDTH=8 operation from an aligned point (#1 after posedge, IDLE).
    task automatic do_op8(input logic [7:0] ta, input logic [7:0] tb, input logic tc,
                          input logic ts, output logic [8:0] exp,
                          output int lat, output int nbusy);
        exp    = ref8(ta, tb, tc, ts);
        start8 = 1'b1;
        a8     = ta;
        b8     = tb;
        cin8   = tc;
`ifdef SERIAL_ADDER_SUB_EN
        sub8   = ts;
`endif
        @(posedge clk); #1;
        start8 = 1'b0;
        a8     = 8'($urandom);
        b8     = 8'($urandom);
        cin8   = 1'($urandom);
`ifdef SERIAL_ADDER_SUB_EN
        sub8   = 1'($urandom);
`endif
        lat   = 0;
        nbusy = busy8 ? 1 : 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            lat++;
            if (busy8) nbusy++;
            if (done8) break;
        end
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        n_checks++; if (busy8 !== 1'b0) $display("FAIL reset_busy8: got %b expected 0", busy8); else n_pass++;
        n_checks++; if (done8 !== 1'b0) $display("FAIL reset_done8: got %b expected 0", done8); else n_pass++;
        n_checks++; if (sum8 !== 8'h00) $display("FAIL reset_sum8: got %h expected 00", sum8); else n_pass++;
        n_checks++; if (cout8 !== 1'b0) $display("FAIL reset_cout8: got %b expected 0", cout8); else n_pass++;
        n_checks++; if ({busy1, done1, sum1, cout1} !== 4'b0000)
            $display("FAIL reset_dut1: got %b expected 0000", {busy1, done1, sum1, cout1}); else n_pass++;
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_add_directed();
        logic [7:0] ta [3] = '{8'h5A, 8'hFF, 8'hFF};
        logic [7:0] tb [3] = '{8'h3C, 8'h01, 8'h00};
        logic       tc [3] = '{1'b0, 1'b0, 1'b1};
        logic [8:0] exp;
        int         lat, nb;
        for (int i = 0; i < 3; i++) begin
            do_op8(ta[i], tb[i], tc[i], 1'b0, exp, lat, nb);
            n_checks++; if (lat !== 9) $display("FAIL dir_latency[%0d]: got %0d expected 9", i, lat); else n_pass++;
            n_checks++; if (nb !== 8) $display("FAIL dir_busy_cycles[%0d]: got %0d expected 8", i, nb); else n_pass++;
            n_checks++; if (sum8 !== exp[7:0]) $display("FAIL dir_sum[%0d]: got %h expected %h", i, sum8, exp[7:0]); else n_pass++;
            n_checks++; if (cout8 !== exp[8]) $display("FAIL dir_cout[%0d]: got %b expected %b", i, cout8, exp[8]); else n_pass++;
            repeat (3) @(posedge clk);
            #1;
            n_checks++; if ({cout8, sum8} !== exp)
                $display("FAIL dir_hold[%0d]: got %h expected %h", i, {cout8, sum8}, exp); else n_pass++;
        end
    endtask

    task automatic test_add_random();
        logic [8:0] exp;
        logic [7:0] ta, tb;
        logic       tc;
        int         lat, nb;
        for (int i = 0; i < 20; i++) begin
            ta = 8'($urandom);
            tb = 8'($urandom);
            tc = 1'($urandom);
            do_op8(ta, tb, tc, 1'b0, exp, lat, nb);
            n_checks++; if ({cout8, sum8} !== exp || lat !== 9)
                $display("FAIL rand_add[%0d]: %h+%h+%b got %h lat %0d expected %h lat 9",
                         i, ta, tb, tc, {cout8, sum8}, lat, exp); else n_pass++;
        end
    endtask

    task automatic test_ignore_start();
        int         ndone;
        logic [7:0] got;
        ndone  = 0;
        got    = 8'hXX;
        start8 = 1'b1;
        a8     = 8'h01;
        b8     = 8'h02;
        cin8   = 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
        sub8   = 1'b0;
`endif
        @(posedge clk); #1;
        a8 = 8'h11;
        b8 = 8'h22;
        for (int c = 0; c < 24; c++) begin
            if (c == 3) start8 = 1'b0;
            @(posedge clk); #1;
            if (done8) begin
                ndone++;
                if (ndone == 1) got = sum8;
            end
        end
        n_checks++; if (ndone !== 1) $display("FAIL ignore_done_count: got %0d expected 1", ndone); else n_pass++;
        n_checks++; if (got !== 8'h03) $display("FAIL ignore_sum: got %h expected 03", got); else n_pass++;
    endtask

    task automatic test_reset_mid_run();
        logic       pre_busy;
        logic [7:0] pre_sum;
        int         ndone;
        logic [8:0] exp;
        int         lat, nb;
        start8 = 1'b1;
        a8     = 8'hFF;
        b8     = 8'h00;
        cin8   = 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
        sub8   = 1'b0;
`endif
        @(posedge clk); #1;
        start8 = 1'b0;
        repeat (4) @(posedge clk);
        #3;
        pre_busy = busy8;
        pre_sum  = sum8;
        rst_n    = 1'b0;
        #1;
        n_checks++; if (pre_busy !== 1'b1) $display("FAIL midrst_pre_busy: got %b expected 1", pre_busy); else n_pass++;
        n_checks++; if (pre_sum !== 8'hF0) $display("FAIL midrst_partial_sum: got %h expected f0", pre_sum); else n_pass++;
        n_checks++; if ({busy8, done8, sum8, cout8} !== 11'd0)
            $display("FAIL midrst_outputs: got busy %b done %b sum %h cout %b expected all 0",
                     busy8, done8, sum8, cout8); else n_pass++;
        @(posedge clk); #1;
        rst_n = 1'b1;
        ndone = 0;
        for (int c = 0; c < 15; c++) begin
            @(posedge clk); #1;
            if (done8 || busy8) ndone++;
        end
        n_checks++; if (ndone !== 0) $display("FAIL midrst_no_done: got %0d active cycles expected 0", ndone); else n_pass++;
        do_op8(8'h0F, 8'h01, 1'b0, 1'b0, exp, lat, nb);
        n_checks++; if ({cout8, sum8} !== exp || lat !== 9)
            $display("FAIL midrst_next_op: got %h lat %0d expected %h lat 9", {cout8, sum8}, lat, exp); else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic [7:0] qa [4];
        logic [7:0] qb [4];
        logic       qc [4];
        logic [8:0] exp;
        int         idx, cyc, last;
        for (int i = 0; i < 4; i++) begin
            qa[i] = 8'($urandom);
            qb[i] = 8'($urandom);
            qc[i] = 1'($urandom);
        end
        idx  = 0;
        cyc  = 0;
        last = 0;
        start8 = 1'b1;
        a8 = qa[0]; b8 = qb[0]; cin8 = qc[0];
`ifdef SERIAL_ADDER_SUB_EN
        sub8 = 1'b0;
`endif
        for (int c = 0; c < 60 && idx < 4; c++) begin
            @(posedge clk); #1;
            cyc++;
            if (done8) begin
                exp = ref8(qa[idx], qb[idx], qc[idx], 1'b0);
                n_checks++; if ({cout8, sum8} !== exp)
                    $display("FAIL b2b_result[%0d]: got %h expected %h", idx, {cout8, sum8}, exp); else n_pass++;
                if (idx > 0) begin
                    n_checks++; if (cyc - last !== 10)
                        $display("FAIL b2b_spacing[%0d]: got %0d expected 10", idx, cyc - last); else n_pass++;
                end
                last = cyc;
                idx++;
                if (idx < 4) begin
                    a8 = qa[idx]; b8 = qb[idx]; cin8 = qc[idx];
                end
            end
        end
        start8 = 1'b0;
        n_checks++; if (idx !== 4) $display("FAIL b2b_count: got %0d expected 4", idx); else n_pass++;
        repeat (12) @(posedge clk);
        #1;
    endtask

    task automatic test_width1();
        int lat, tot;
        for (int i = 0; i < 8; i++) begin
            tot    = i[0] + i[1] + i[2];
            a1     = i[0];
            b1     = i[1];
            cin1   = i[2];
            start1 = 1'b1;
            @(posedge clk); #1;
            start1 = 1'b0;
            a1 = ~a1; b1 = ~b1; cin1 = ~cin1;
            lat = 0;
            for (int c = 0; c < 6; c++) begin
                @(posedge clk); #1;
                lat++;
                if (done1) break;
            end
            n_checks++; if (sum1 !== 1'(tot % 2) || cout1 !== 1'(tot / 2) || lat !== 2)
                $display("FAIL w1_fa[%0d]: got sum %b cout %b lat %0d expected sum %0d cout %0d lat 2",
                         i, sum1, cout1, lat, tot % 2, tot / 2); else n_pass++;
        end
    endtask

`ifdef SERIAL_ADDER_SUB_EN
    task automatic test_sub();
        logic [8:0] exp;
        logic [7:0] ta, tb;
        int         lat, nb;
        do_op8(8'h10, 8'h01, 1'b0, 1'b1, exp, lat, nb);
        n_checks++; if ({cout8, sum8} !== 9'h10F) $display("FAIL sub_10_01: got %h expected 10f", {cout8, sum8}); else n_pass++;
        do_op8(8'h01, 8'h02, 1'b1, 1'b1, exp, lat, nb);
        n_checks++; if ({cout8, sum8} !== 9'h0FF) $display("FAIL sub_01_02: got %h expected 0ff", {cout8, sum8}); else n_pass++;
        for (int i = 0; i < 10; i++) begin
            ta = 8'($urandom);
            tb = 8'($urandom);
            do_op8(ta, tb, 1'($urandom), 1'b1, exp, lat, nb);
            n_checks++; if ({cout8, sum8} !== exp || cout8 !== (ta >= tb))
                $display("FAIL sub_rand[%0d]: %h-%h got %h expected %h", i, ta, tb, {cout8, sum8}, exp); else n_pass++;
        end
    endtask
`endif

    initial begin
        n_checks = 0;
        n_pass   = 0;
        rst_n    = 1'b0;
        start8   = 1'b0;
        a8       = 8'h00;
        b8       = 8'h00;
        cin8     = 1'b0;
        start1   = 1'b0;
        a1       = 1'b0;
        b1       = 1'b0;
        cin1     = 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
        sub8     = 1'b0;
        sub1     = 1'b0;
`endif
        test_reset();
        test_add_directed();
        test_add_random();
        test_ignore_start();
        test_reset_mid_run();
        test_back_to_back();
        test_width1();
`ifdef SERIAL_ADDER_SUB_EN
        test_sub();
`endif
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
